// File: rtl/mips_ss_pkg.sv
// rtl/mips_ss_pkg.sv - shared opcodes, decode and queue entry type for the dual-issue stage
package mips_ss_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_IMM_LO = 6'h08;
  localparam logic [5:0] OP_IMM_HI = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  typedef struct packed {
    logic [4:0] dest;
    logic       dest_v;
    logic [4:0] src1;
    logic       src1_v;
    logic [4:0] src2;
    logic       src2_v;
    logic       is_mem;
    logic       is_branch;
    logic       is_load;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr1;
    logic [31:0] instr2;
  } entry_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [5:0] op;
    logic [4:0] dst;
    logic       has_dst;
    logic       unused_low;
    op         = instr[31:26];
    unused_low = ^instr[10:0];
    d          = '0;
    d.src1     = instr[25:21];
    d.src2     = instr[20:16];
    dst        = '0;
    has_dst    = 1'b0;
    if (op == OP_RTYPE) begin
      dst      = instr[15:11];
      has_dst  = 1'b1;
      d.src1_v = 1'b1;
      d.src2_v = 1'b1;
    end else if ((op >= OP_IMM_LO && op <= OP_IMM_HI) || op == OP_LW) begin
      dst       = instr[20:16];
      has_dst   = 1'b1;
      d.src1_v  = 1'b1;
      d.is_mem  = (op == OP_LW);
      d.is_load = (op == OP_LW);
    end else if (op == OP_SW || op == OP_BEQ || op == OP_BNE) begin
      d.src1_v    = 1'b1;
      d.src2_v    = 1'b1;
      d.is_mem    = (op == OP_SW);
      d.is_branch = (op != OP_SW);
    end
    // Writes to $0 are discarded, so they never create a hazard.
    d.dest   = dst;
    d.dest_v = has_dst && (dst != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - per-register countdown scoreboard with two load ports and 3+3 busy lookups
module issue_scoreboard #(
  parameter int CW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld0_en,
  input  logic [4:0]      ld0_reg,
  input  logic [CW-1:0]   ld0_val,
  input  logic            ld1_en,
  input  logic [4:0]      ld1_reg,
  input  logic [CW-1:0]   ld1_val,
  input  logic [2:0][4:0] q0_reg,
  output logic [2:0]      q0_busy,
  input  logic [2:0][4:0] q1_reg,
  output logic [2:0]      q1_busy
);

  logic [CW-1:0] cnt_q [32];
  logic [CW-1:0] cnt_d [32];

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
      if (ld0_en && ld0_reg == 5'(r)) cnt_d[r] = ld0_val;
      if (ld1_en && ld1_reg == 5'(r)) cnt_d[r] = ld1_val;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      q0_busy[i] = (q0_reg[i] != 5'd0) && (cnt_q[q0_reg[i]] != '0);
      q1_busy[i] = (q1_reg[i] != 5'd0) && (cnt_q[q1_reg[i]] != '0);
    end
  end

endmodule

// File: rtl/dual_issue_unit.sv
// rtl/dual_issue_unit.sv - in-order dual-issue stage: pair queue, pair splitting, scoreboard holds
// ISSUE_FWD_EN selects forwarding release times (lw 2, others 0) instead of WB_LAT for every destination.
module dual_issue_unit
  import mips_ss_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WB_LAT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [31:0]                fetch_pc,
  input  logic [31:0]                fetch_instr1,
  input  logic [31:0]                fetch_instr2,
  input  logic                       flush,
  input  logic                       issue_ready,
  output logic                       issue0_valid,
  output logic                       issue1_valid,
  output logic [31:0]                issue0_instr,
  output logic [31:0]                issue1_instr,
  output logic [31:0]                issue0_pc,
  output logic [31:0]                issue1_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam int MAXL = (WB_LAT > 2) ? WB_LAT : 2;
  localparam int CW   = $clog2(MAXL);
`ifdef ISSUE_FWD_EN
  localparam int unsigned LAT_LOAD  = 2;
  localparam int unsigned LAT_OTHER = 0;
`else
  localparam int unsigned LAT_LOAD  = WB_LAT;
  localparam int unsigned LAT_OTHER = WB_LAT;
`endif

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            half_q, half_d;

  entry_t      head;
  dec_t        dec1, dec2, a_dec;
  logic [31:0] a_instr, a_pc;
  logic [2:0]  busy_a, busy_b;
  logic        a_ok, b_ok, raw, waw, push, pop;
  logic [CW-1:0] hold_a, hold_b;
  logic        unused_dest_busy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The counter holds T-1: a consumer checks the pre-edge value, so T-1 decrements
  // after the producer's edge it reaches zero exactly T edges later.
  function automatic logic [CW-1:0] hold_cycles(input dec_t d);
    int unsigned t;
    t = d.is_load ? LAT_LOAD : LAT_OTHER;
    return (t == 0) ? '0 : CW'(t - 1);
  endfunction

  always_comb begin
    head    = mem_q[rd_ptr_q];
    dec1    = decode(head.instr1);
    dec2    = decode(head.instr2);
    a_dec   = half_q ? dec2 : dec1;
    a_instr = half_q ? head.instr2 : head.instr1;
    a_pc    = half_q ? head.pc + 32'd4 : head.pc;
    hold_a  = hold_cycles(a_dec);
    hold_b  = hold_cycles(dec2);
  end

  issue_scoreboard #(.CW(CW)) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .ld0_en  (a_ok && a_dec.dest_v && (hold_a != '0)),
    .ld0_reg (a_dec.dest),
    .ld0_val (hold_a),
    .ld1_en  (b_ok && dec2.dest_v && (hold_b != '0)),
    .ld1_reg (dec2.dest),
    .ld1_val (hold_b),
    .q0_reg  ({a_dec.dest, a_dec.src2, a_dec.src1}),
    .q0_busy (busy_a),
    .q1_reg  ({dec2.dest, dec2.src2, dec2.src1}),
    .q1_busy (busy_b)
  );

  assign unused_dest_busy = busy_a[2] ^ busy_b[2];

  always_comb begin
    a_ok = (count_q != '0) && issue_ready && !flush
           && !(a_dec.src1_v && busy_a[0]) && !(a_dec.src2_v && busy_a[1]);
    raw  = a_dec.dest_v && ((dec2.src1_v && dec2.src1 == a_dec.dest)
                         || (dec2.src2_v && dec2.src2 == a_dec.dest));
    waw  = a_dec.dest_v && dec2.dest_v && (dec2.dest == a_dec.dest);
    b_ok = a_ok && !half_q
           && !(dec2.src1_v && busy_b[0]) && !(dec2.src2_v && busy_b[1])
           && !raw && !waw && !(a_dec.is_mem && dec2.is_mem) && !a_dec.is_branch;
    pop  = a_ok && (b_ok || half_q);
    push = fetch_valid && fetch_ready && !flush;
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    half_d   = half_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      half_d   = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: fetch_pc, instr1: fetch_instr1, instr2: fetch_instr2};
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (pop)       half_d = 1'b0;
      else if (a_ok) half_d = 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      half_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      half_q   <= half_d;
    end
  end

  assign fetch_ready  = (count_q != CNTW'(DEPTH));
  assign count        = count_q;
  assign issue0_valid = a_ok;
  assign issue1_valid = b_ok;
  assign issue0_instr = a_ok ? a_instr : '0;
  assign issue0_pc    = a_ok ? a_pc : '0;
  assign issue1_instr = b_ok ? head.instr2 : '0;
  assign issue1_pc    = b_ok ? head.pc + 32'd4 : '0;

endmodule

// File: doc/dual_issue_unit.md
# dual_issue_unit

Parametrised in-order dual-issue stage for the superscalar MIPS pipeline. It sits between the dual fetch registers and the dual execute stage, and buffers fetched instruction pairs in a queue of depth DEPTH. Each cycle it issues zero, one or two instructions. Pairs are split on intra-pair hazards and on structural conflicts, and any instruction whose source registers are still in flight is held by a per-register scoreboard.

## Interface
- DEPTH, 4: queue depth in instruction pairs; at least 2.
- WB_LAT, 4: cycles from issue until the destination register is released; at least 1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fetch_valid  in  1  a pair is offered.
- fetch_ready  out  1  the queue accepts the pair; equals count != DEPTH.
- fetch_pc  in  32  byte address of fetch_instr1; fetch_instr2 is at fetch_pc+4.
- fetch_instr1, fetch_instr2  in  32 each  instruction words.
- flush  in  1  discard all queued instructions.
- issue_ready  in  1  the back end accepts this cycle's issue.
- issue0_valid, issue1_valid  out  1 each  slot issues.
- issue0_instr, issue1_instr  out  32 each  instruction per slot.
- issue0_pc, issue1_pc  out  32 each  byte address per slot.
- count  out  $clog2(DEPTH+1)  occupied pair entries.

## Operation
- Decode of each instruction word:
  - opcode 0 (R-type): destination rd; sources rs, rt.
  - opcodes 0x08–0x0F, and 0x23 (lw): destination rt; source rs.
  - 0x2B (sw), 0x04 (beq), 0x05 (bne): no destination; sources rs, rt.
  - Other opcodes: no destination, no sources.
  - Destination $0 counts as no destination. Register $0 is never busy.
  - lw and sw are memory operations; beq and bne are branches.
- Head candidates:
  - If the `half` flag is clear: A = instr1 and B = instr2.
  - If `half` is set: A = instr2 and there is no B.
- A issues in slot 0 when all of the following hold: the queue is non-empty, issue_ready is high, flush is low, and no source of A is busy.
- B issues in slot 1 only when all of the following hold:
  - A issues.
  - No source of B is busy.
  - B does not read A's destination (RAW).
  - B does not write A's destination (WAW).
  - A and B are not both memory operations.
  - A is not a branch.
- If A is blocked, nothing issues; issue is strictly in order.
- Result of an issue:
  - A and B both issue, or A issues with `half` set: pop the head entry and clear `half`.
  - A issues alone with `half` clear: set `half`; the entry stays at the head.
- Slot-0 pc is entry.pc, or entry.pc+4 when `half` is set. Slot-1 pc is entry.pc+4.
- Outputs are combinational from the head entry, `half` and the scoreboard. Invalid slots drive zero instruction and pc.
- Scoreboard: `issue_scoreboard` sub-module, one countdown per register.
  - On issue, the destination counter loads its release time.
  - Every non-zero counter decrements each cycle. A load wins over a decrement on the same cycle.
  - busy means counter != 0. Busy checks use the pre-edge value.
  - Slot-0 and slot-1 loads never target the same register, because WAW blocks pairing.
- Push and pop:
  - Push happens on fetch_valid && fetch_ready && !flush.
  - Push and pop may occur in the same cycle when not full.
  - When full, fetch_ready stays low even if a pop is occurring.
- Flush:
  - Empties the queue and clears `half` on the next edge.
  - A push in the same cycle is dropped.
  - The scoreboard is not cleared; in-flight writes still complete.
- Reset: all outputs 0 except fetch_ready = 1, which is not full. The queue, `half` and the scoreboard are cleared.

## Timing
- A pair pushed at edge N is first eligible for issue in cycle N+1.
- An issue takes effect at the edge where the slot is valid and issue_ready is high.
- Dependent instruction: if the producer issues at edge N, the consumer issues no earlier than edge N+T, where T is the producer's release time (see Configuration).
- count changes by -1, 0 or +1 per edge.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Asserting reset mid-operation forces the reset values asynchronously, with no edge needed.

## Configuration
- ISSUE_FWD_EN defined: the execute stage forwards results.
  - Release time is 2 for lw and 0 for all other destinations. A release time of 0 means the register is never marked busy.
  - Intra-pair RAW and WAW still split the pair.
- ISSUE_FWD_EN undefined: release time is WB_LAT for every destination.

## Structure
- Shared package `mips_ss_pkg` holds:
  - opcode constants;
  - a decode function returning dest, src1, src2 and their valids, plus is_mem and is_branch;
  - the queue-entry struct {pc, instr1, instr2}.
- Sub-module `issue_scoreboard`: 32 countdown counters; per-slot load ports; three busy lookups per slot.

## Test plan
- `add $1,$2,$3` / `add $4,$5,$6` at pc 0x100 → both slots valid in one cycle; pcs 0x100 and 0x104; count returns to 0.
- `add $3,$1,$2` / `add $4,$3,$3`, no ISSUE_FWD_EN, WB_LAT=4 → slot 0 issues at edge N; the second instruction issues in slot 0 at edge N+4 with pc+4.
- `lw $5,0($1)` / `sw $6,4($2)` → split; the sw issues alone on the next cycle.
- DEPTH=4, issue_ready=0, five pushes offered → four accepted; fetch_ready=0 and count=4.
- `half` set on the head entry, then flush → next cycle count=0 and both valids low; a busy destination still blocks later readers.
- Reset asserted between edges during issue → valids 0, count 0 and fetch_ready 1 immediately.
